mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_starve_cnt.sv | 44 ++++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data memory arbiter:
//   - owner_t       : which requester the outstanding read belongs to
//   - *_DEF         : default parameter values used by mem_arbiter
//   - word_in_range : true when a word address lies inside the shared memory
// No ports (package).
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 30;
  localparam int MEMSIZE_DEF    = 131072;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IRD  = 2'd1,
    DRD  = 2'd2
  } owner_t;

  // Memory size is given in bytes, addresses are word addresses.
  function automatic logic word_in_range(input logic [63:0] addr, input int memsize);
    return (addr < (64'(memsize) / 64'd4));
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// ----------------------------------------------------------------------------
// arb_starve_cnt
// Counts consecutive cycles in which the instruction port requests but is
// not granted. Saturates at STARVE_MAX; o_force is high while saturated.
// Ports:
//   clk     in  clock
//   reset   in  synchronous active-low reset
//   i_req   in  instruction request
//   i_gnt   in  instruction grant this cycle
//   o_force out count has reached STARVE_MAX
// ----------------------------------------------------------------------------
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_force
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;

  // Denied-request counter, cleared whenever the request drops or is served.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (!i_req || i_gnt) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_force = (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one shared
// single-ported memory, one access per cycle. Data wins ties unless the
// instruction port has been denied STARVE_MAX cycles in a row.
// Ports:
//   clk, reset (sync, active low)
//   i_req/i_addr -> i_gnt, i_rvalid, i_rdata           instruction port
//   d_req/d_we/d_addr/d_wdata/d_wbyte -> d_gnt, d_rvalid, d_rdata  data port
//   m_read_ready/m_read_address, m_read_data (1-cycle latency)      memory read
//   m_write_ready/m_write_address/m_write_data/m_write_byte         memory write
//   err  sticky out-of-range access flag
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MEMSIZE    = MEMSIZE_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wbyte,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_read_ready,
  output logic [ADDR_W-1:0] m_read_address,
  output logic              m_write_ready,
  output logic [ADDR_W-1:0] m_write_address,
  output logic [31:0]       m_write_data,
  output logic [3:0]        m_write_byte,
  input  logic [31:0]       m_read_data,
  output logic              err
);

  logic              w_force;
  logic              w_i_gnt;
  logic              w_d_gnt;
  logic              w_rd;
  logic              w_wr;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_rd_data;
  owner_t            w_owner_nxt;

  owner_t            r_owner;
  logic              r_rd_oor;
  logic              r_err;
  logic [31:0]       r_i_hold;
  logic [31:0]       r_d_hold;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_gnt   (w_i_gnt),
    .o_force (w_force)
  );

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (reset) begin
      if (i_req && (!d_req || w_force)) begin
        w_i_gnt = 1'b1;
      end else if (d_req) begin
        w_d_gnt = 1'b1;
      end else begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
      end
    end else begin
      w_i_gnt = 1'b0;
      w_d_gnt = 1'b0;
    end
  end

  assign w_addr     = w_i_gnt ? i_addr : d_addr;
  assign w_rd       = w_i_gnt | (w_d_gnt & ~d_we);
  assign w_wr       = w_d_gnt & d_we;
  assign w_in_range = word_in_range(64'(w_addr), MEMSIZE);

  // Memory strobes; out-of-range grants are accepted but never reach memory.
  always_comb begin
    m_read_ready    = 1'b0;
    m_read_address  = {ADDR_W{1'b0}};
    m_write_ready   = 1'b0;
    m_write_address = {ADDR_W{1'b0}};
    m_write_data    = 32'h0000_0000;
    m_write_byte    = 4'b0000;
    if (w_rd && w_in_range) begin
      m_read_ready   = 1'b1;
      m_read_address = w_addr;
    end else if (w_wr && w_in_range) begin
      m_write_ready   = 1'b1;
      m_write_address = d_addr;
      m_write_data    = d_wdata;
      m_write_byte    = d_wbyte;
    end else begin
      m_read_ready  = 1'b0;
      m_write_ready = 1'b0;
    end
  end

  // Owner of the read issued this cycle, if any.
  always_comb begin
    if (w_i_gnt) begin
      w_owner_nxt = IRD;
    end else if (w_d_gnt && !d_we) begin
      w_owner_nxt = DRD;
    end else begin
      w_owner_nxt = NONE;
    end
  end

  // An out-of-range read still completes, but with zero data.
  assign w_rd_data = r_rd_oor ? 32'h0000_0000 : m_read_data;

  // Outstanding-read owner, error flag and per-port read data hold registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner  <= NONE;
      r_rd_oor <= 1'b0;
      r_err    <= 1'b0;
      r_i_hold <= 32'h0000_0000;
      r_d_hold <= 32'h0000_0000;
    end else begin
      r_owner  <= w_owner_nxt;
      r_rd_oor <= w_rd & ~w_in_range;
      r_err    <= r_err | ((w_i_gnt | w_d_gnt) & ~w_in_range);
      if (r_owner == IRD) begin
        r_i_hold <= w_rd_data;
      end else begin
        r_i_hold <= r_i_hold;
      end
      if (r_owner == DRD) begin
        r_d_hold <= w_rd_data;
      end else begin
        r_d_hold <= r_d_hold;
      end
    end
  end

  // Route returning read data to its owner; other port shows its last value.
  always_comb begin
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = 32'h0000_0000;
    d_rdata  = 32'h0000_0000;
    if (reset) begin
      i_rdata = r_i_hold;
      d_rdata = r_d_hold;
      case (r_owner)
        IRD: begin
          i_rvalid = 1'b1;
          i_rdata  = w_rd_data;
        end
        DRD: begin
          d_rvalid = 1'b1;
          d_rdata  = w_rd_data;
        end
        NONE: begin
          i_rvalid = 1'b0;
          d_rvalid = 1'b0;
        end
        default: begin
          i_rvalid = 1'b0;
          d_rvalid = 1'b0;
        end
      endcase
    end else begin
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
    end
  end

  assign i_gnt = w_i_gnt;
  assign d_gnt = w_d_gnt;
  assign err   = r_err;

endmodule
